pe_array_ctrl: RTL and testbench

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/pe_array_ctrl_pkg.sv | 39 +++
 rtl/pe_array_ctrl_if.sv | 37 +++
 rtl/pe_array_ctrl.sv | 127 ++++++++++++
 tb/tb_pe_array_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pe_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pe_array_ctrl_pkg : shared types and constants for the PE array controller.
// Revision 1.0
// ============================================================================
package pe_array_ctrl_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned DRAIN_CYCLES = 4;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } op_mode_e;

  typedef enum logic [1:0] {
    STAGE_IDLE        = 2'd0,
    STAGE_LOAD_FILTER = 2'd1,
    STAGE_CONV        = 2'd2,
    STAGE_DRAIN       = 2'd3
  } op_stage_e;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  packet_idx;
    logic [DATA_W-1:0] data;
  } pe_in_packet_t;

  // MODE4 always loads three filter packets; the other modes load one per PE row.
  function automatic logic [IDX_W-1:0] last_packet_idx(input op_mode_e m,
                                                        input int unsigned num_rows);
    return (m == MODE4) ? IDX_W'(2) : IDX_W'(num_rows - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_array_ctrl_if.sv
`default_nettype none
// ============================================================================
// pe_array_ctrl_if : job request, filter handshake and PE broadcast signals.
// Revision 1.0
// ============================================================================
interface pe_array_ctrl_if
  import pe_array_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic                start;
  op_mode_e            mode_in;
  logic [CNT_W-1:0]    conv_len;
  logic                filt_valid;
  logic [DATA_W-1:0]   filt_data;
  logic                filt_ready;
  logic                array_stall;
  op_mode_e            mode;
  logic                change_mode;
  op_stage_e           op_stage;
  pe_in_packet_t       pe_packet;
  logic                busy;
  logic                done;

  modport master (
    output start, mode_in, conv_len, filt_valid, filt_data, array_stall,
    input  filt_ready, mode, change_mode, op_stage, pe_packet, busy, done
  );

  modport slave (
    input  start, mode_in, conv_len, filt_valid, filt_data, array_stall,
    output filt_ready, mode, change_mode, op_stage, pe_packet, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// pe_array_ctrl : sequences one job through config, filter load, conv and drain.
// Revision 1.0
// ============================================================================
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  pe_array_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CFG         = 3'd1,
    LOAD_FILTER = 3'd2,
    CONV        = 3'd3,
    DRAIN       = 3'd4,
    DONE        = 3'd5
  } state_e;

  state_e           state_q, state_d;
  op_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0] conv_len_q, conv_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pkt_q, pkt_d;
  logic [IDX_W-1:0] last_idx;
  logic             in_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE1;
      conv_len_q <= '0;
      cnt_q      <= '0;
      pkt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      conv_len_q <= conv_len_d;
      cnt_q      <= cnt_d;
      pkt_q      <= pkt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    conv_len_d = conv_len_q;
    cnt_d      = cnt_q;
    pkt_d      = pkt_q;
    last_idx   = last_packet_idx(mode_q, NUM_ROWS);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = CFG;
          mode_d     = bus.mode_in;
          conv_len_d = bus.conv_len;
          cnt_d      = '0;
          pkt_d      = '0;
        end
      end
      CFG: state_d = LOAD_FILTER;
      LOAD_FILTER: begin
        // filt_ready is constant 1 here, so filt_valid alone marks a transfer.
        if (bus.filt_valid) begin
          if (pkt_q == last_idx) begin
            pkt_d   = '0;
            state_d = (conv_len_q == '0) ? DRAIN : CONV;
          end else begin
            pkt_d = pkt_q + IDX_W'(1);
          end
        end
      end
      CONV: begin
        if (!bus.array_stall) begin
          if (cnt_q == conv_len_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state only; filt_valid/filt_data pass straight into the packet.
  always_comb begin
    in_load         = (state_q == LOAD_FILTER);
    bus.mode        = mode_q;
    bus.change_mode = (state_q == CFG);
    bus.busy        = (state_q != IDLE);
    bus.done        = (state_q == DONE);
    bus.filt_ready  = in_load;
    bus.pe_packet   = '0;
    bus.op_stage    = STAGE_IDLE;
    if (in_load) begin
      bus.pe_packet.valid      = bus.filt_valid;
      bus.pe_packet.packet_idx = pkt_q;
      bus.pe_packet.data       = bus.filt_data;
    end
    case (state_q)
      LOAD_FILTER: bus.op_stage = STAGE_LOAD_FILTER;
      CONV:        bus.op_stage = STAGE_CONV;
      DRAIN:       bus.op_stage = STAGE_DRAIN;
      default:     bus.op_stage = STAGE_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pe_array_ctrl : directed jobs with a queue-based scoreboard on the PE broadcast.
// Revision 1.0
// ============================================================================
module tb_pe_array_ctrl;
  import pe_array_ctrl_pkg::*;

  localparam int unsigned CNT_W = 16;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } exp_pkt_t;

  typedef struct {
    int done_cyc;
    int conv;
    int npkts;
  } exp_job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic rst_s = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   conv_cnt = 0;
  int   drain_cnt = 0;
  int   pkt_cnt = 0;

  exp_pkt_t exp_pkt_q[$];
  exp_job_t exp_job_q[$];
  op_mode_e exp_mode_q[$];

  pe_array_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pe_array_ctrl #(
    .NUM_ROWS (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: samples on the falling edge, pops expectations as events appear.
  always @(negedge clk) begin : mon
    exp_pkt_t p;
    exp_job_t j;
    if (cyc > 0) begin
      if (rst_s) begin
        chk("rst_mode",        64'(bus.mode), 64'(MODE1));
        chk("rst_change_mode", 64'(bus.change_mode), 64'd0);
        chk("rst_op_stage",    64'(bus.op_stage), 64'(STAGE_IDLE));
        chk("rst_pe_packet",   64'(bus.pe_packet), 64'd0);
        chk("rst_filt_ready",  64'(bus.filt_ready), 64'd0);
        chk("rst_busy",        64'(bus.busy), 64'd0);
        chk("rst_done",        64'(bus.done), 64'd0);
      end else begin
        chk("ready_vs_stage", 64'(bus.filt_ready), 64'(bus.op_stage == STAGE_LOAD_FILTER));
        chk("busy_decode", 64'(bus.busy),
            64'(bus.op_stage != STAGE_IDLE || bus.change_mode || bus.done));
        if (bus.change_mode) begin
          if (exp_mode_q.size() == 0) chk("unexpected_change_mode", 64'd1, 64'd0);
          else chk("cfg_mode", 64'(bus.mode), 64'(exp_mode_q.pop_front()));
          conv_cnt  = 0;
          drain_cnt = 0;
          pkt_cnt   = 0;
        end
        if (bus.op_stage == STAGE_CONV)  conv_cnt++;
        if (bus.op_stage == STAGE_DRAIN) drain_cnt++;
        if (bus.pe_packet.valid) begin
          pkt_cnt++;
          if (exp_pkt_q.size() == 0) chk("unexpected_packet", 64'd1, 64'd0);
          else begin
            p = exp_pkt_q.pop_front();
            chk("pkt_idx",  64'(bus.pe_packet.packet_idx), 64'(p.idx));
            chk("pkt_data", 64'(bus.pe_packet.data), 64'(p.data));
          end
        end
        if (bus.done) begin
          if (exp_job_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            j = exp_job_q.pop_front();
            chk("done_cycle",   64'(cyc), 64'(j.done_cyc));
            chk("conv_cycles",  64'(conv_cnt), 64'(j.conv));
            chk("drain_cycles", 64'(drain_cnt), 64'(DRAIN_CYCLES));
            chk("packet_count", 64'(pkt_cnt), 64'(j.npkts));
          end
        end
      end
    end
  end

  // One job: inputs are driven 1 time unit after each rising edge, slot s = cycles since start.
  // lf/conv are the hand-counted LOAD_FILTER and CONV lengths; DONE lands at slot 6+lf+conv.
  task automatic run_job(input int id, input op_mode_e m, input int conv_len,
                         input bit toggle, input int stall_at, input int stall_len,
                         input int npkts, input int lf, input int conv,
                         input int rst_at, input int extra_start);
    int L;
    int c;
    int idx;
    bit fv;
    logic [DATA_W-1:0] d;
    L   = 6 + lf + conv;
    idx = 0;
    @(posedge clk); #1;
    c = cyc;
    exp_mode_q.push_back(m);
    if (rst_at < 0) exp_job_q.push_back('{c + L, conv, npkts});
    for (int s = 0; s <= L; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      fv = toggle ? ((s % 2) == 0) : 1'b1;
      d  = {16'hF00D, 8'(id), 8'(s)};
      bus.start       = (s == 0) || (extra_start >= 0 && (s == extra_start || s == L));
      bus.mode_in     = (s == 0) ? m : MODE4;
      bus.conv_len    = (s == 0) ? CNT_W'(conv_len) : CNT_W'(7);
      bus.filt_valid  = fv;
      bus.filt_data   = d;
      bus.array_stall = (stall_at >= 0 && s >= stall_at && s < stall_at + stall_len);
      rst             = (s == rst_at);
      if (s >= 2 && s < 2 + lf && fv) begin
        exp_pkt_q.push_back('{IDX_W'(idx), d});
        idx++;
      end
      if (s == rst_at) break;
    end
    @(posedge clk); #1;
    bus.start       = 1'b0;
    bus.filt_valid  = 1'b0;
    bus.array_stall = 1'b0;
    rst             = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.mode_in     = MODE1;
    bus.conv_len    = '0;
    bus.filt_valid  = 1'b0;
    bus.filt_data   = '0;
    bus.array_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    //       id mode   len tog stall len pkts lf conv rst  xstart
    run_job(1, MODE1, 5,  0,  -1,   0,  4,   4, 5,   -1,  -1);
    run_job(2, MODE4, 2,  0,  -1,   0,  3,   3, 2,   -1,  -1);
    run_job(3, MODE2, 1,  1,  -1,   0,  4,   7, 1,   -1,  -1);
    run_job(4, MODE1, 3,  0,   7,   2,  4,   4, 5,   -1,  -1);
    run_job(5, MODE3, 0,  0,  -1,   0,  4,   4, 0,   -1,   3);
    run_job(6, MODE2, 5,  0,  -1,   0,  4,   4, 5,    8,  -1);
    run_job(7, MODE4, 1,  0,  -1,   0,  3,   3, 1,   -1,  -1);

    repeat (4) @(posedge clk);
    #1;
    chk("pkt_queue_empty",  64'(exp_pkt_q.size()), 64'd0);
    chk("job_queue_empty",  64'(exp_job_q.size()), 64'd0);
    chk("mode_queue_empty", 64'(exp_mode_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
